sha256_nonce_scheduler: RTL and testbench
=========================================

SHA256_NONCE_SCHEDULER -- requirements
Module: sha256_nonce_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles to wait for core_done after core_start.
REQ-002 SHALL have parameter STOP_ON_FOUND, default 1; 1 = end job at first hit, 0 = resume scan after hit accepted.
REQ-003 SHALL have clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have rst  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have job_valid  input  1 / job_ready  output  1  job handshake.
REQ-006 SHALL have job_nonce_start  input  32 / job_nonce_end  input  32  inclusive nonce range.
REQ-007 SHALL have job_target  input  256  difficulty target, unsigned.
REQ-008 SHALL have abort  input  1  cancel current job.
REQ-009 SHALL have core_start  output  1  one-cycle start pulse to SHA-256 core.
REQ-010 SHALL have core_nonce  output  32  nonce for the current core run.
REQ-011 SHALL have core_done  input  1 / core_hash  input  256  core completion pulse and final hash.
REQ-012 SHALL have found_valid  output  1 / found_ready  input  1 / found_nonce  output  32  hit handshake.
REQ-013 SHALL have busy  output  1, job_done  output  1 (one-cycle pulse), timeout_err  output  1 (sticky), hash_count  output  32.

Function
REQ-014 States: IDLE, ISSUE, WAIT, CHECK, REPORT; state encoding is free.
REQ-015 job_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-016 IDLE: on job_valid&&job_ready, latch start/end/target, clear timeout_err and hash_count, set nonce=start; go ISSUE; if start>end instead pulse job_done next cycle, stay IDLE, no core_start.
REQ-017 ISSUE: core_start=1 for exactly one cycle, core_nonce=current nonce (held stable until next ISSUE); go WAIT.
REQ-018 WAIT: on core_done, register core_hash and go CHECK; core_done is ignored in all other states.
REQ-019 WAIT: wait counter increments each cycle; on reaching TIMEOUT without core_done, set timeout_err, pulse job_done, go IDLE.
REQ-020 CHECK: hash_count += 1, saturating at 0xFFFFFFFF; hit = registered hash < latched target (256-bit unsigned, strict).
REQ-021 CHECK: on hit go REPORT; else if nonce==end pulse job_done, go IDLE; else nonce+1, go ISSUE.
REQ-022 REPORT: found_valid=1, found_nonce=hit nonce, both held until found_ready; on accept: STOP_ON_FOUND=1 or nonce==end -> pulse job_done, go IDLE; else nonce+1, go ISSUE.
REQ-023 Nonce never wraps: end=0xFFFFFFFF terminates after that nonce; increment never produces 0 within a job.
REQ-024 abort (any non-IDLE state) has priority over all other events: next state IDLE, found_valid deasserted, no job_done, no further core_start; abort in IDLE has no effect.
REQ-025 Minimum per-nonce loop without hit: ISSUE->WAIT->(core_done)->CHECK->ISSUE; core_start pulses of consecutive nonces separated by core latency + 3 cycles.

Reset
REQ-026 rst==0 at a rising edge: state IDLE; job_ready=1 from the first cycle after reset release; core_start, found_valid, busy, job_done, timeout_err=0; hash_count, core_nonce, found_nonce=0.
REQ-027 Reset mid-job SHALL drop the job without job_done or found report; a core_done arriving after reset is ignored.

Verification
REQ-028 Range 5..7, target all-ones, core_done 64 cycles after start -> core_start for nonce 5 only, found_nonce=5, STOP_ON_FOUND=1 job_done after accept, hash_count=1.
REQ-029 Range 0x10..0x13, target 0, STOP_ON_FOUND=0 -> 4 core_start pulses with nonces 0x10..0x13, no found_valid, one job_done, hash_count=4.
REQ-030 Range 0xFFFFFFFE..0xFFFFFFFF, target 0 -> nonces FFFFFFFE, FFFFFFFF, then job_done; no wrap to 0.
REQ-031 STOP_ON_FOUND=0, hits at nonces 2 and 4 of range 1..5, found_ready held 0 for 10 cycles -> found_valid/found_nonce=2 stable 10 cycles, no core_start meanwhile; then nonce 4 reported; job_done after nonce 5.
REQ-032 TIMEOUT=8, core never responds -> timeout_err=1 exactly 8 cycles after WAIT entry, job_done pulse, job_ready=1 next cycle.
REQ-033 abort asserted in WAIT, then rst=0 during a second job -> both return to IDLE with no job_done, no found_valid, all outputs at reset values.

Source files
------------

// File: rtl/sha256_nonce_scheduler_if.sv
// Handshake bundle between the nonce scheduler, its job source, the SHA-256 core and the hit consumer.
// The master side is the scheduler; the slave side is whatever surrounds it.
interface sha256_nonce_scheduler_if;
  logic         job_valid;
  logic         job_ready;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_nonce_end;
  logic [255:0] job_target;

  logic         core_start;
  logic [31:0]  core_nonce;
  logic         core_done;
  logic [255:0] core_hash;

  logic         found_valid;
  logic         found_ready;
  logic [31:0]  found_nonce;

  modport master (
    input  job_valid, job_nonce_start, job_nonce_end, job_target,
    input  core_done, core_hash, found_ready,
    output job_ready, core_start, core_nonce, found_valid, found_nonce
  );

  modport slave (
    output job_valid, job_nonce_start, job_nonce_end, job_target,
    output core_done, core_hash, found_ready,
    input  job_ready, core_start, core_nonce, found_valid, found_nonce
  );
endinterface

// File: rtl/sha256_nonce_scheduler.sv
// Nonce scheduler: walks an inclusive nonce range through an external SHA-256 core and
// reports every nonce whose hash is strictly below the job target.
module sha256_nonce_scheduler #(
  parameter int unsigned TIMEOUT       = 255,
  parameter int          STOP_ON_FOUND = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  sha256_nonce_scheduler_if.master bus,
  input  logic                     abort,
  output logic                     busy,
  output logic                     job_done,
  output logic                     timeout_err,
  output logic [31:0]              hash_count
);
  // state  | meaning
  // IDLE   | ready to accept a job
  // ISSUE  | core_start pulse for nonce_q
  // WAIT   | waiting for core_done, bounded by TIMEOUT cycles
  // CHECK  | count the hash and compare it against the target
  // REPORT | hold found_nonce until the consumer accepts it
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_REPORT
  } state_e;

  // Counter only needs to reach TIMEOUT-1; the timeout fires on the cycle it gets there.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e         state_q;
  logic [31:0]    nonce_q;
  logic [31:0]    end_q;
  logic [255:0]   target_q;
  logic [255:0]   hash_q;
  logic [CW-1:0]  wait_cnt_q;
  logic           core_start_q;
  logic [31:0]    core_nonce_q;
  logic           found_valid_q;
  logic [31:0]    found_nonce_q;
  logic           job_done_q;
  logic           timeout_err_q;
  logic [31:0]    hash_count_q;

  logic           last_nonce_d;
  logic [31:0]    nonce_inc_d;
  logic           hit_d;
  logic           wait_last_d;
  logic [31:0]    hash_count_d;

  assign last_nonce_d = (nonce_q == end_q);
  assign nonce_inc_d  = nonce_q + 32'd1;
  assign hit_d        = (hash_q < target_q);
  assign wait_last_d  = (wait_cnt_q == CW'(TIMEOUT - 1));
  assign hash_count_d = (hash_count_q == 32'hFFFF_FFFF) ? hash_count_q : hash_count_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      nonce_q       <= '0;
      end_q         <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      wait_cnt_q    <= '0;
      core_start_q  <= 1'b0;
      core_nonce_q  <= '0;
      found_valid_q <= 1'b0;
      found_nonce_q <= '0;
      job_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      hash_count_q  <= '0;
    end else begin
      core_start_q <= 1'b0;
      job_done_q   <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q       <= S_IDLE;
        found_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.job_valid) begin
              nonce_q       <= bus.job_nonce_start;
              end_q         <= bus.job_nonce_end;
              target_q      <= bus.job_target;
              timeout_err_q <= 1'b0;
              hash_count_q  <= '0;
              // An empty range completes immediately without touching the core.
              if (bus.job_nonce_start > bus.job_nonce_end) begin
                job_done_q <= 1'b1;
              end else begin
                state_q      <= S_ISSUE;
                core_start_q <= 1'b1;
                core_nonce_q <= bus.job_nonce_start;
              end
            end
          end
          S_ISSUE: begin
            state_q    <= S_WAIT;
            wait_cnt_q <= '0;
          end
          S_WAIT: begin
            if (bus.core_done) begin
              hash_q  <= bus.core_hash;
              state_q <= S_CHECK;
            end else if (wait_last_d) begin
              timeout_err_q <= 1'b1;
              job_done_q    <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              wait_cnt_q <= wait_cnt_q + CW'(1);
            end
          end
          S_CHECK: begin
            hash_count_q <= hash_count_d;
            if (hit_d) begin
              state_q       <= S_REPORT;
              found_valid_q <= 1'b1;
              found_nonce_q <= nonce_q;
            end else if (last_nonce_d) begin
              job_done_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              nonce_q      <= nonce_inc_d;
              core_nonce_q <= nonce_inc_d;
              core_start_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
          S_REPORT: begin
            if (bus.found_ready) begin
              found_valid_q <= 1'b0;
              // Checking last_nonce_d first keeps the nonce from ever wrapping past end.
              if ((STOP_ON_FOUND != 0) || last_nonce_d) begin
                job_done_q <= 1'b1;
                state_q    <= S_IDLE;
              end else begin
                nonce_q      <= nonce_inc_d;
                core_nonce_q <= nonce_inc_d;
                core_start_q <= 1'b1;
                state_q      <= S_ISSUE;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.job_ready   = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign bus.core_start  = core_start_q;
  assign bus.core_nonce  = core_nonce_q;
  assign bus.found_valid = found_valid_q;
  assign bus.found_nonce = found_nonce_q;
  assign job_done        = job_done_q;
  assign timeout_err     = timeout_err_q;
  assign hash_count      = hash_count_q;
endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: two instances (stop-on-found with long timeout, resume-after-hit
// with TIMEOUT=8) share stimulus; sel picks which one the core model and monitor follow.
module tb_sha256_nonce_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         job_valid = 1'b0;
  logic [31:0]  job_start = '0;
  logic [31:0]  job_end = '0;
  logic [255:0] job_target = '0;
  logic         abort = 1'b0;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '0;
  logic         found_ready;
  logic         fr_rand = 1'b0;
  int           fr_mode = 0;
  logic         core_en = 1'b1;
  int           lat = 1;
  logic         sel = 1'b0;

  sha256_nonce_scheduler_if ifa ();
  sha256_nonce_scheduler_if ifb ();
  logic busy_a, busy_b, jd_a, jd_b, te_a, te_b;
  logic [31:0] hc_a, hc_b;

  assign ifa.job_valid = job_valid;        assign ifb.job_valid = job_valid;
  assign ifa.job_nonce_start = job_start;  assign ifb.job_nonce_start = job_start;
  assign ifa.job_nonce_end = job_end;      assign ifb.job_nonce_end = job_end;
  assign ifa.job_target = job_target;      assign ifb.job_target = job_target;
  assign ifa.core_done = core_done;        assign ifb.core_done = core_done;
  assign ifa.core_hash = core_hash;        assign ifb.core_hash = core_hash;
  assign ifa.found_ready = found_ready;    assign ifb.found_ready = found_ready;
  assign found_ready = (fr_mode == 0) ? 1'b1 : (fr_mode == 1) ? fr_rand : 1'b0;

  sha256_nonce_scheduler #(.TIMEOUT(255), .STOP_ON_FOUND(1)) u_a (
    .clk(clk), .rst(rst_n), .bus(ifa.master), .abort(abort),
    .busy(busy_a), .job_done(jd_a), .timeout_err(te_a), .hash_count(hc_a));
  sha256_nonce_scheduler #(.TIMEOUT(8), .STOP_ON_FOUND(0)) u_b (
    .clk(clk), .rst(rst_n), .bus(ifb.master), .abort(abort),
    .busy(busy_b), .job_done(jd_b), .timeout_err(te_b), .hash_count(hc_b));

  logic cs_s, jr_s, fv_s, busy_s, jd_s, te_s;
  logic [31:0] cn_s, fn_s, hc_s;
  assign cs_s   = sel ? ifb.core_start  : ifa.core_start;
  assign cn_s   = sel ? ifb.core_nonce  : ifa.core_nonce;
  assign jr_s   = sel ? ifb.job_ready   : ifa.job_ready;
  assign fv_s   = sel ? ifb.found_valid : ifa.found_valid;
  assign fn_s   = sel ? ifb.found_nonce : ifa.found_nonce;
  assign busy_s = sel ? busy_b : busy_a;
  assign jd_s   = sel ? jd_b : jd_a;
  assign te_s   = sel ? te_b : te_a;
  assign hc_s   = sel ? hc_b : hc_a;

  // Hash "oracle": per-nonce hashes, either preset by a test or drawn randomly on first use.
  logic [255:0] htab [logic [31:0]];
  function automatic logic [255:0] get_hash(input logic [31:0] n);
    if (!htab.exists(n))
      htab[n] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return htab[n];
  endfunction

  // Core model: core_done one cycle, lat cycles after the core_start cycle.
  int pend = 0;
  logic [31:0] pend_nonce = '0;
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    fr_rand = 1'($urandom_range(0, 1));
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        core_done = 1'b1;
        core_hash = get_hash(pend_nonce);
      end
    end
    if (rst_n && cs_s && core_en) begin
      pend = lat;
      pend_nonce = cn_s;
    end
  end

  logic [31:0] start_q[$];
  logic [31:0] found_q[$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cs_s) start_q.push_back(cn_s);
      if (fv_s && found_ready) found_q.push_back(fn_s);
      if (jd_s) done_cnt++;
    end
  end

  int tests = 0;
  int fails = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t,
                        input bit with_rst);
    @(posedge clk); #1;
    if (with_rst) begin
      rst_n = 1'b0;
      pend = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    start_q.delete(); found_q.delete(); done_cnt = 0;
    job_start = s; job_end = e; job_target = t; job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == 0) begin
      tests++; fails++;
      $display("FAIL %s: job_done not seen within %0d cycles", name, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_found(input string name, input int budget);
    int k;
    k = 0;
    while (!fv_s && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!fv_s) begin
      tests++; fails++;
      $display("FAIL %s: found_valid not seen within %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    logic         sel;
    logic [31:0]  s, e;
    logic [255:0] t;
    int           lat, hmode, n_starts;
    logic [31:0]  first_s, last_s;
    int           n_found;
    logic [31:0]  found0;
    int           hc;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(logic sl, logic [31:0] s, logic [31:0] e, logic [255:0] t,
                                  int lt, int hm, int ns, logic [31:0] fs, logic [31:0] ls,
                                  int nf, logic [31:0] f0, int hc);
    vec_t v;
    v.sel = sl; v.s = s; v.e = e; v.t = t; v.lat = lt; v.hmode = hm; v.n_starts = ns;
    v.first_s = fs; v.last_s = ls; v.n_found = nf; v.found0 = f0; v.hc = hc;
    vecs.push_back(v);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] TGT  = {32'h8000_0000, 192'h0, 32'h0000_0123};

  initial begin
    logic [31:0] exp_s[$];
    logic [31:0] exp_f[$];
    logic [31:0] rs, re, n;
    logic [255:0] tt;
    longint ee;
    int len, ehc, hold_ok, cs_k, te_k, n0;
    bit fin, hit, jd_at_te, jr_at_te;

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst job_ready a", 64'(ifa.job_ready), 64'd1);
    check("rst job_ready b", 64'(ifb.job_ready), 64'd1);
    check("rst busy", 64'({busy_a, busy_b}), 64'd0);
    check("rst core_start", 64'({ifa.core_start, ifb.core_start}), 64'd0);
    check("rst found_valid", 64'({ifa.found_valid, ifb.found_valid}), 64'd0);
    check("rst flags", 64'({jd_a, jd_b, te_a, te_b}), 64'd0);
    check("rst hash_count", 64'(hc_a | hc_b), 64'd0);
    check("rst nonces", 64'(ifa.core_nonce | ifa.found_nonce | ifb.core_nonce), 64'd0);

    // sel, start, end, target, lat, hmode(0 rnd,1 =tgt,2 =tgt-1), starts, first, last, founds, found0, hc
    add_vec(1'b0, 32'd5, 32'd7, ONES, 64, 0, 1, 32'd5, 32'd5, 1, 32'd5, 1);
    add_vec(1'b1, 32'h10, 32'h13, '0, 2, 0, 4, 32'h10, 32'h13, 0, 32'd0, 4);
    add_vec(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, '0, 3, 0, 2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 32'd0, 2);
    add_vec(1'b0, 32'd9, 32'd3, ONES, 1, 0, 0, 32'd0, 32'd0, 0, 32'd0, 0);
    add_vec(1'b1, 32'd42, 32'd42, '0, 1, 0, 1, 32'd42, 32'd42, 0, 32'd0, 1);
    add_vec(1'b0, 32'd100, 32'd103, TGT, 2, 1, 4, 32'd100, 32'd103, 0, 32'd0, 4);
    add_vec(1'b0, 32'd100, 32'd103, TGT, 2, 2, 1, 32'd100, 32'd100, 1, 32'd100, 1);
    add_vec(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, TGT, 5, 2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1);
    add_vec(1'b1, 32'd7, 32'd9, TGT, 3, 2, 3, 32'd7, 32'd9, 3, 32'd7, 3);

    foreach (vecs[i]) begin
      sel = vecs[i].sel; lat = vecs[i].lat; core_en = 1'b1; fr_mode = 0;
      htab.delete();
      if (vecs[i].hmode != 0)
        for (longint k = longint'(vecs[i].s); k <= longint'(vecs[i].e); k++)
          htab[32'(k)] = (vecs[i].hmode == 1) ? vecs[i].t : vecs[i].t - 256'd1;
      launch(vecs[i].s, vecs[i].e, vecs[i].t, 1'b1);
      wait_done($sformatf("v%0d", i), 2000);
      check($sformatf("v%0d n_starts", i), 64'(start_q.size()), 64'(vecs[i].n_starts));
      if (vecs[i].n_starts > 0 && start_q.size() > 0) begin
        check($sformatf("v%0d first nonce", i), 64'(start_q[0]), 64'(vecs[i].first_s));
        check($sformatf("v%0d last nonce", i), 64'(start_q[start_q.size()-1]), 64'(vecs[i].last_s));
      end
      check($sformatf("v%0d n_found", i), 64'(found_q.size()), 64'(vecs[i].n_found));
      if (vecs[i].n_found > 0 && found_q.size() > 0)
        check($sformatf("v%0d found0", i), 64'(found_q[0]), 64'(vecs[i].found0));
      check($sformatf("v%0d hash_count", i), 64'(hc_s), 64'(vecs[i].hc));
      check($sformatf("v%0d job_done count", i), 64'(done_cnt), 64'd1);
      check($sformatf("v%0d idle after", i), 64'({jr_s, busy_s}), 64'b10);
    end

    // Randomized jobs against the range-walk reference model
    for (int j = 0; j < 12; j++) begin
      sel = 1'($urandom_range(0, 1)); lat = int'($urandom_range(1, 6));
      core_en = 1'b1; fr_mode = 1;
      htab.delete();
      len = int'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) rs = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      else rs = $urandom;
      ee = longint'(rs) + longint'(len);
      if (ee > 64'hFFFF_FFFF) ee = 64'hFFFF_FFFF;
      re = 32'(ee);
      tt = {32'h4000_0000, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      launch(rs, re, tt, 1'b1);
      wait_done($sformatf("rnd%0d", j), 3000);
      exp_s.delete(); exp_f.delete(); ehc = 0; n = rs; fin = 1'b0;
      while (!fin) begin
        exp_s.push_back(n); ehc++;
        hit = (get_hash(n) < tt);
        if (hit) exp_f.push_back(n);
        if ((hit && sel == 1'b0) || n == re) fin = 1'b1;
        else n = n + 32'd1;
      end
      check($sformatf("rnd%0d n_starts", j), 64'(start_q.size()), 64'(exp_s.size()));
      for (int k = 0; k < exp_s.size() && k < start_q.size(); k++)
        check($sformatf("rnd%0d start[%0d]", j, k), 64'(start_q[k]), 64'(exp_s[k]));
      check($sformatf("rnd%0d n_found", j), 64'(found_q.size()), 64'(exp_f.size()));
      for (int k = 0; k < exp_f.size() && k < found_q.size(); k++)
        check($sformatf("rnd%0d found[%0d]", j, k), 64'(found_q[k]), 64'(exp_f[k]));
      check($sformatf("rnd%0d hash_count", j), 64'(hc_s), 64'(ehc));
      check($sformatf("rnd%0d job_done count", j), 64'(done_cnt), 64'd1);
    end

    // Resume mode with a stalled consumer: hits at 2 and 4 of 1..5
    sel = 1'b1; lat = 2; core_en = 1'b1; fr_mode = 2;
    htab.delete();
    htab[32'd1] = ONES; htab[32'd2] = '0; htab[32'd3] = ONES; htab[32'd4] = '0; htab[32'd5] = ONES;
    launch(32'd1, 32'd5, 256'h1 << 128, 1'b1);
    wait_found("hold found", 200);
    hold_ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (fv_s && fn_s == 32'd2 && !cs_s) hold_ok++;
      @(negedge clk);
    end
    check("hold found stable cycles", 64'(hold_ok), 64'd10);
    check("hold no core_start", 64'(start_q.size()), 64'd2);
    @(posedge clk); #1 fr_mode = 0;
    wait_done("hold", 500);
    check("hold n_found", 64'(found_q.size()), 64'd2);
    if (found_q.size() == 2) check("hold second found", 64'(found_q[1]), 64'd4);
    check("hold n_starts", 64'(start_q.size()), 64'd5);
    check("hold hash_count", 64'(hc_s), 64'd5);
    check("hold job_done count", 64'(done_cnt), 64'd1);

    // Timeout with a silent core, TIMEOUT=8
    sel = 1'b1; core_en = 1'b0; fr_mode = 0;
    launch(32'd0, 32'd3, TGT, 1'b1);
    cs_k = -1; te_k = -1; jd_at_te = 1'b0; jr_at_te = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cs_s && cs_k < 0) cs_k = k;
      if (te_s && te_k < 0) begin
        te_k = k; jd_at_te = jd_s; jr_at_te = jr_s;
      end
    end
    check("timeout start to err cycles", 64'(te_k - cs_k), 64'd9);
    check("timeout job_done with err", 64'(jd_at_te), 64'd1);
    check("timeout job_ready with err", 64'(jr_at_te), 64'd1);
    check("timeout job_done count", 64'(done_cnt), 64'd1);
    check("timeout sticky", 64'(te_s), 64'd1);
    core_en = 1'b1; lat = 1;
    launch(32'd0, 32'd0, '0, 1'b0);
    @(negedge clk);
    check("timeout cleared by new job", 64'(te_s), 64'd0);
    wait_done("after timeout", 200);

    // Abort while waiting on the core
    sel = 1'b0; core_en = 1'b0; fr_mode = 0;
    launch(32'd0, 32'd10, ONES, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort wait idle", 64'({jr_s, busy_s, fv_s}), 64'b100);
    repeat (20) @(negedge clk);
    check("abort wait starts", 64'(start_q.size()), 64'd1);
    check("abort wait no job_done", 64'(done_cnt), 64'd0);

    // Abort while a hit is pending
    core_en = 1'b1; lat = 2; fr_mode = 2;
    launch(32'd0, 32'd10, ONES, 1'b1);
    wait_found("abort report", 200);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort report found_valid", 64'(fv_s), 64'd0);
    check("abort report idle", 64'({jr_s, busy_s}), 64'b10);
    repeat (10) @(negedge clk);
    check("abort report no job_done", 64'(done_cnt), 64'd0);
    fr_mode = 0;

    // Reset mid-job with a core_done still in flight
    sel = 1'b0; core_en = 1'b1; lat = 20;
    launch(32'd0, 32'd100, '0, 1'b1);
    for (int k = 0; k < 200 && start_q.size() < 2; k++) @(negedge clk);
    check("reset job progressed", 64'(start_q.size() >= 2), 64'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset outputs strobes", 64'({cs_s, fv_s, busy_s, jd_s, te_s}), 64'd0);
    check("reset job_ready", 64'(jr_s), 64'd1);
    check("reset counters", 64'({hc_s, cn_s | fn_s}), 64'd0);
    n0 = start_q.size();
    repeat (40) @(negedge clk);
    check("reset no later start", 64'(start_q.size()), 64'(n0));
    check("reset no job_done", 64'(done_cnt), 64'd0);
    check("reset stays idle", 64'({busy_s, fv_s, hc_s}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
